// File: rtl/mem_stage_ctrl.sv
// Memory stage between EX and WB: stores and non-memory ops complete in 1 cycle, loads in RD_LAT+2.
// busy holds off upstream for the whole load, from issue until the read data is captured.
module mem_stage_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1,
  localparam int LANES = DATA_W / 8,
  localparam int OFF_W = $clog2(DATA_W / 8)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ex_en,
  input  logic [3:0]              ex_mem_op,
  input  logic [DATA_W-1:0]       ex_mem_wr_data,
  input  logic [ADDR_W-1:0]       ex_out,
  output logic                    busy,
  output logic                    mem_en,
  output logic [ADDR_W-OFF_W-1:0] addr,
  output logic [DATA_W-1:0]       wr_data,
  output logic [LANES-1:0]        wea,
  input  logic [DATA_W-1:0]       rd_data,
  output logic [DATA_W-1:0]       out,
  output logic                    out_valid,
  output logic                    miss_align
);

  localparam logic [3:0] OP_LW  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LB  = 4'd4;
  localparam logic [3:0] OP_LBU = 4'd5;
  localparam logic [3:0] OP_SW  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SB  = 4'd8;

  localparam logic [1:0] LAST_WAIT = 2'(RD_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_WAIT,
    LOAD_CAP
  } state_t;

  state_t             state;
  logic [1:0]         cnt;
  logic [3:0]         ld_op;
  logic [OFF_W-1:0]   ld_off;

  logic [OFF_W-1:0]   off;
  logic               is_load;
  logic               is_store;
  logic               is_word;
  logic               is_half;
  logic               aligned;
  logic [LANES-1:0]   st_wea;
  logic [DATA_W-1:0]  st_dat;
  logic [DATA_W-1:0]  rd_lane;
  logic [DATA_W-1:0]  ld_val;

  // Request decode; unknown opcodes fall through as non-memory ops.
  always_comb begin
    off      = ex_out[OFF_W-1:0];
    is_load  = (ex_mem_op >= OP_LW) && (ex_mem_op <= OP_LBU);
    is_store = (ex_mem_op >= OP_SW) && (ex_mem_op <= OP_SB);
    is_word  = (ex_mem_op == OP_LW) || (ex_mem_op == OP_SW);
    is_half  = (ex_mem_op == OP_LH) || (ex_mem_op == OP_LHU) || (ex_mem_op == OP_SH);
    if (is_word) begin
      aligned = (off == '0);
    end else if (is_half) begin
      aligned = ~off[0];
    end else begin
      aligned = 1'b1;
    end
  end

  always_comb begin
    st_dat = ex_mem_wr_data << {off, 3'b000};
    case (ex_mem_op)
      OP_SW:   st_wea = '1;
      OP_SH:   st_wea = LANES'(3) << off;
      OP_SB:   st_wea = LANES'(1) << off;
      default: st_wea = '0;
    endcase
  end

  // Load lane extraction uses the op/offset captured at issue, not the live EX inputs.
  always_comb begin
    rd_lane = rd_data >> {ld_off, 3'b000};
    case (ld_op)
      OP_LB:   ld_val = {{(DATA_W-8){rd_lane[7]}}, rd_lane[7:0]};
      OP_LBU:  ld_val = {{(DATA_W-8){1'b0}}, rd_lane[7:0]};
      OP_LH:   ld_val = {{(DATA_W-16){rd_lane[15]}}, rd_lane[15:0]};
      OP_LHU:  ld_val = {{(DATA_W-16){1'b0}}, rd_lane[15:0]};
      default: ld_val = rd_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      ld_op      <= '0;
      ld_off     <= '0;
      busy       <= 1'b0;
      mem_en     <= 1'b0;
      addr       <= '0;
      wr_data    <= '0;
      wea        <= '0;
      out        <= '0;
      out_valid  <= 1'b0;
      miss_align <= 1'b0;
    end else begin
      mem_en     <= 1'b0;
      wea        <= '0;
      out_valid  <= 1'b0;
      miss_align <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_en) begin
            if ((is_load || is_store) && !aligned) begin
              miss_align <= 1'b1;
            end else if (is_load) begin
              mem_en <= 1'b1;
              addr   <= ex_out[ADDR_W-1:OFF_W];
              ld_op  <= ex_mem_op;
              ld_off <= off;
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= LOAD_WAIT;
            end else if (is_store) begin
              mem_en    <= 1'b1;
              addr      <= ex_out[ADDR_W-1:OFF_W];
              wea       <= st_wea;
              wr_data   <= st_dat;
              out       <= '0;
              out_valid <= 1'b1;
            end else begin
              out       <= DATA_W'(ex_out);
              out_valid <= 1'b1;
            end
          end
        end
        LOAD_WAIT: begin
          if (cnt == LAST_WAIT) begin
            state <= LOAD_CAP;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        LOAD_CAP: begin
          out       <= ld_val;
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench: a 32-bit instance (RD_LAT=2) and a 64-bit instance (RD_LAT=3) share one stimulus bus.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_en;
  logic [3:0]  op;
  logic [63:0] wdat;
  logic [31:0] exo;
  logic [63:0] rd;
  logic        sel;

  logic        en32, en64;
  logic        busy32, mem_en32, ov32, miss32;
  logic [29:0] addr32;
  logic [31:0] wr32, out32;
  logic [3:0]  wea32;
  logic        busy64, mem_en64, ov64, miss64;
  logic [28:0] addr64;
  logic [63:0] wr64, out64;
  logic [7:0]  wea64;

  logic        m_busy, m_mem_en, m_ov, m_miss;
  logic [63:0] m_addr, m_wr, m_out;
  logic [7:0]  m_wea;

  int total = 0;
  int bad = 0;

  localparam logic [63:0] JUNK = 64'hA5A5_5A5A_C3C3_3C3C;

  always #5 clk = ~clk;

  assign en32 = ex_en & ~sel;
  assign en64 = ex_en & sel;

  mem_stage_ctrl #(.DATA_W(32), .ADDR_W(32), .RD_LAT(2)) u32 (
    .clk(clk), .rst(rst), .ex_en(en32), .ex_mem_op(op), .ex_mem_wr_data(wdat[31:0]),
    .ex_out(exo), .busy(busy32), .mem_en(mem_en32), .addr(addr32), .wr_data(wr32),
    .wea(wea32), .rd_data(rd[31:0]), .out(out32), .out_valid(ov32), .miss_align(miss32)
  );

  mem_stage_ctrl #(.DATA_W(64), .ADDR_W(32), .RD_LAT(3)) u64 (
    .clk(clk), .rst(rst), .ex_en(en64), .ex_mem_op(op), .ex_mem_wr_data(wdat),
    .ex_out(exo), .busy(busy64), .mem_en(mem_en64), .addr(addr64), .wr_data(wr64),
    .wea(wea64), .rd_data(rd), .out(out64), .out_valid(ov64), .miss_align(miss64)
  );

  assign m_busy   = sel ? busy64 : busy32;
  assign m_mem_en = sel ? mem_en64 : mem_en32;
  assign m_ov     = sel ? ov64 : ov32;
  assign m_miss   = sel ? miss64 : miss32;
  assign m_addr   = sel ? 64'(addr64) : 64'(addr32);
  assign m_wr     = sel ? wr64 : 64'(wr32);
  assign m_out    = sel ? out64 : 64'(out32);
  assign m_wea    = sel ? wea64 : 8'(wea32);

  typedef struct {
    logic        sel;
    logic [3:0]  op;
    logic [31:0] a;
    logic [63:0] d;
    logic [63:0] r;
    logic        e_mem;
    logic [7:0]  e_wea;
    logic [63:0] e_wr;
    logic        e_miss;
    int          e_vc;
    logic [63:0] e_out;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic s, input logic [3:0] o, input logic [31:0] a,
                              input logic [63:0] d, input logic [63:0] r, input logic e_mem,
                              input logic [7:0] e_wea, input logic [63:0] e_wr,
                              input logic e_miss, input int e_vc, input logic [63:0] e_out);
    vec_t t;
    t.sel = s; t.op = o; t.a = a; t.d = d; t.r = r; t.e_mem = e_mem; t.e_wea = e_wea;
    t.e_wr = e_wr; t.e_miss = e_miss; t.e_vc = e_vc; t.e_out = e_out;
    vq.push_back(t);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One transaction: drive at T, check issue outputs at T+1, then watch out_valid/busy
  // while presenting rd_data only in the cycle the BRAM would return it.
  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    int vcyc;
    int vcnt;
    int bcnt;
    logic [63:0] vout;
    logic ld;
    lat  = v.sel ? 3 : 2;
    vcyc = 0; vcnt = 0; bcnt = 0; vout = '0;
    ld   = (v.op >= 4'd1) && (v.op <= 4'd5) && !v.e_miss;
    @(negedge clk);
    sel = v.sel; ex_en = 1'b1; op = v.op; exo = v.a; wdat = v.d; rd = JUNK;
    @(negedge clk);
    ex_en = 1'b0; op = 4'd0;
    chk($sformatf("v%0d mem_en", idx), 64'(m_mem_en), 64'(v.e_mem));
    chk($sformatf("v%0d wea", idx), 64'(m_wea), 64'(v.e_wea));
    chk($sformatf("v%0d miss_align", idx), 64'(m_miss), 64'(v.e_miss));
    if (v.e_mem) chk($sformatf("v%0d addr", idx), m_addr, 64'(v.sel ? v.a >> 3 : v.a >> 2));
    if (v.e_mem && !ld) chk($sformatf("v%0d wr_data", idx), m_wr, v.e_wr);
    for (int k = 1; k <= lat + 3; k++) begin
      if (k > 1) @(negedge clk);
      rd = (k == lat + 1) ? v.r : JUNK;
      if (m_busy) bcnt++;
      if (m_ov) begin
        vcnt++;
        if (vcyc == 0) begin
          vcyc = k;
          vout = m_out;
        end
      end
    end
    chk($sformatf("v%0d valid_cycle", idx), 64'(vcyc), 64'(v.e_vc));
    chk($sformatf("v%0d valid_count", idx), 64'(vcnt), 64'((v.e_vc != 0) ? 1 : 0));
    if (v.e_vc != 0) chk($sformatf("v%0d out", idx), vout, v.e_out);
    chk($sformatf("v%0d busy_cycles", idx), 64'(bcnt), 64'(ld ? lat + 1 : 0));
  endtask

  initial begin
    int mcnt;
    int ocnt;
    logic [63:0] vout;
    vec_t t;

    rst = 1'b1; ex_en = 1'b0; op = '0; exo = '0; wdat = '0; rd = '0; sel = 1'b0;

    //  sel op    addr       wdata                  rd_data                mem wea    wr_data                miss vc out
    add(0, 4'd8, 32'h1003, 64'hAB,                64'h0,                 1, 8'h08, 64'hAB000000,          0, 1, 64'h0);
    add(0, 4'd4, 32'h2001, 64'h0,                 64'h12348000,          1, 8'h00, 64'h0,                 0, 4, 64'hFFFFFF80);
    add(0, 4'd5, 32'h2001, 64'h0,                 64'h12348000,          1, 8'h00, 64'h0,                 0, 4, 64'h00000080);
    add(0, 4'd2, 32'h0002, 64'h0,                 64'h80011234,          1, 8'h00, 64'h0,                 0, 4, 64'hFFFF8001);
    add(0, 4'd1, 32'h0006, 64'h0,                 64'h0,                 0, 8'h00, 64'h0,                 1, 0, 64'h0);
    add(0, 4'd0, 32'h005A, 64'h0,                 64'h0,                 0, 8'h00, 64'h0,                 0, 1, 64'h5A);
    add(0, 4'd7, 32'h0002, 64'h1234,              64'h0,                 1, 8'h0C, 64'h12340000,          0, 1, 64'h0);
    add(0, 4'd6, 32'h0000, 64'hCAFEF00D,          64'h0,                 1, 8'h0F, 64'hCAFEF00D,          0, 1, 64'h0);
    add(0, 4'd3, 32'h0002, 64'h0,                 64'h80011234,          1, 8'h00, 64'h0,                 0, 4, 64'h00008001);
    add(0, 4'd1, 32'h0004, 64'h0,                 64'h89ABCDEF,          1, 8'h00, 64'h0,                 0, 4, 64'h89ABCDEF);
    add(0, 4'd7, 32'h0001, 64'h0,                 64'h0,                 0, 8'h00, 64'h0,                 1, 0, 64'h0);
    add(0, 4'd15, 32'h0077, 64'h0,                64'h0,                 0, 8'h00, 64'h0,                 0, 1, 64'h77);
    add(0, 4'd4, 32'h0003, 64'h0,                 64'h7F000000,          1, 8'h00, 64'h0,                 0, 4, 64'h7F);
    add(1, 4'd7, 32'h000C, 64'hBEEF,              64'h0,                 1, 8'h30, 64'h0000BEEF00000000,  0, 1, 64'h0);
    add(1, 4'd1, 32'h0008, 64'h0,                 64'h1122334455667788,  1, 8'h00, 64'h0,                 0, 5, 64'h1122334455667788);
    add(1, 4'd1, 32'h0004, 64'h0,                 64'h0,                 0, 8'h00, 64'h0,                 1, 0, 64'h0);
    add(1, 4'd2, 32'h0006, 64'h0,                 64'h8765000000000000,  1, 8'h00, 64'h0,                 0, 5, 64'hFFFFFFFFFFFF8765);
    add(1, 4'd8, 32'h0007, 64'h5C,                64'h0,                 1, 8'h80, 64'h5C00000000000000,  0, 1, 64'h0);
    add(1, 4'd0, 32'h005A, 64'h0,                 64'h0,                 0, 8'h00, 64'h0,                 0, 1, 64'h5A);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk($sformatf("rst%0d busy", s), 64'(m_busy), 64'h0);
      chk($sformatf("rst%0d mem_en", s), 64'(m_mem_en), 64'h0);
      chk($sformatf("rst%0d addr", s), m_addr, 64'h0);
      chk($sformatf("rst%0d wr_data", s), m_wr, 64'h0);
      chk($sformatf("rst%0d wea", s), 64'(m_wea), 64'h0);
      chk($sformatf("rst%0d out", s), m_out, 64'h0);
      chk($sformatf("rst%0d out_valid", s), 64'(m_ov), 64'h0);
      chk($sformatf("rst%0d miss_align", s), 64'(m_miss), 64'h0);
    end

    for (int i = 0; i < vq.size(); i++) run_vec(vq[i], i);

    // Request pulsed mid-load must be dropped: one mem_en, one out_valid.
    @(negedge clk);
    sel = 1'b0; ex_en = 1'b1; op = 4'd4; exo = 32'h2001; rd = JUNK;
    mcnt = 0; ocnt = 0; vout = '0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (m_mem_en) mcnt++;
      if (m_ov) begin
        ocnt++;
        vout = m_out;
      end
      ex_en = (k == 2);
      op    = (k == 2) ? 4'd0 : 4'd4;
      exo   = (k == 2) ? 32'h33 : 32'h2001;
      rd    = (k == 3) ? 64'h12348000 : JUNK;
    end
    chk("busy_ignore mem_en_count", 64'(mcnt), 64'd1);
    chk("busy_ignore valid_count", 64'(ocnt), 64'd1);
    chk("busy_ignore out", vout, 64'hFFFFFF80);

    // Back-to-back stores, one per cycle.
    @(negedge clk);
    sel = 1'b0; ex_en = 1'b1; op = 4'd8; exo = 32'h0; wdat = 64'h11;
    @(negedge clk);
    chk("b2b first wea", 64'(m_wea), 64'h01);
    chk("b2b first wr_data", m_wr, 64'h11);
    exo = 32'h1; wdat = 64'h22;
    @(negedge clk);
    ex_en = 1'b0;
    chk("b2b second wea", 64'(m_wea), 64'h02);
    chk("b2b second wr_data", m_wr, 64'h2200);
    chk("b2b second mem_en", 64'(m_mem_en), 64'h1);
    chk("b2b second out_valid", 64'(m_ov), 64'h1);
    @(negedge clk);
    chk("b2b idle mem_en", 64'(m_mem_en), 64'h0);
    chk("b2b idle wea", 64'(m_wea), 64'h0);
    chk("b2b idle wr_data hold", m_wr, 64'h2200);

    // New request accepted in the cycle the load's out_valid pulses.
    @(negedge clk);
    ex_en = 1'b1; op = 4'd1; exo = 32'h0; rd = JUNK;
    @(negedge clk);
    ex_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rd = 64'h0BADCAFE;
    @(negedge clk);
    rd = JUNK;
    chk("overlap load valid", 64'(m_ov), 64'h1);
    chk("overlap load out", m_out, 64'h0BADCAFE);
    chk("overlap busy", 64'(m_busy), 64'h0);
    ex_en = 1'b1; op = 4'd0; exo = 32'h99;
    @(negedge clk);
    ex_en = 1'b0;
    chk("overlap next valid", 64'(m_ov), 64'h1);
    chk("overlap next out", m_out, 64'h99);

    // Reset in the middle of an RD_LAT=3 load.
    @(negedge clk);
    sel = 1'b1; ex_en = 1'b1; op = 4'd1; exo = 32'h8; rd = JUNK;
    @(negedge clk);
    ex_en = 1'b0;
    chk("rstload busy T+1", 64'(m_busy), 64'h1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstload busy", 64'(m_busy), 64'h0);
    chk("rstload mem_en", 64'(m_mem_en), 64'h0);
    chk("rstload addr", m_addr, 64'h0);
    chk("rstload wr_data", m_wr, 64'h0);
    chk("rstload wea", 64'(m_wea), 64'h0);
    chk("rstload out", m_out, 64'h0);
    chk("rstload out_valid", 64'(m_ov), 64'h0);
    chk("rstload miss_align", 64'(m_miss), 64'h0);
    ocnt = 0;
    for (int k = 4; k <= 9; k++) begin
      rd = (k == 4) ? 64'h1122334455667788 : JUNK;
      @(negedge clk);
      if (m_ov) ocnt++;
    end
    chk("rstload no valid", 64'(ocnt), 64'h0);
    t = vq[vq.size() - 1];
    run_vec(t, 99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
